// File: rtl/if_prefetch_stage_pkg.sv
// ==================================================================
// if_prefetch_stage_pkg : shared bus widths, reset PC and FSM states
// Revision: 1.0
// ==================================================================
`default_nettype none

package if_prefetch_stage_pkg;

  localparam int          BR_BUS_WD        = 33;
  localparam int          IF_TO_ID_BUS_WD  = 64;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_prefetch_stage_if.sv
// ==================================================================
// if_prefetch_stage_if : ID-side and instruction-memory-side signals
// Revision: 1.0
// ==================================================================
`default_nettype none

interface if_prefetch_stage_if;
  import if_prefetch_stage_pkg::*;

  logic                       id_allow_in;
  logic [BR_BUS_WD-1:0]       redirect_bus;
  logic                       if_to_id_valid;
  logic [IF_TO_ID_BUS_WD-1:0] if_to_id_bus;
  logic [31:0]                PC;
  logic                       inst_req_valid;
  logic                       inst_req_ready;
  logic [31:0]                instruction;
  logic                       inst_valid;
  logic                       inst_ready;
  logic                       MemRead;

  modport master (
    input  id_allow_in, redirect_bus, inst_req_ready, instruction, inst_valid, MemRead,
    output if_to_id_valid, if_to_id_bus, PC, inst_req_valid, inst_ready
  );

  modport slave (
    output id_allow_in, redirect_bus, inst_req_ready, instruction, inst_valid, MemRead,
    input  if_to_id_valid, if_to_id_bus, PC, inst_req_valid, inst_ready
  );

endinterface

`default_nettype wire

// File: rtl/if_prefetch_stage_fifo.sv
// ==================================================================
// fetch_fifo : synchronous FIFO with flush and occupancy count
// Revision: 1.0
// ==================================================================
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_prefetch_stage.sv
// ==================================================================
// if_prefetch_stage : instruction prefetch with in-order tag queue,
// instruction buffer and redirect-driven response dropping
// Revision: 1.0
// ==================================================================
`default_nettype none

module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_stage_if.master bus
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam int SW = BW + 2;

  if (BUF_DEPTH < 2 || BUF_DEPTH > 16 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("BUF_DEPTH must be a power of two in 2..16");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > BUF_DEPTH) begin : g_chk_outst
    $error("MAX_OUTST must be in 1..BUF_DEPTH");
  end

  fetch_state_e               r_state;
  fetch_state_e               w_state_nxt;
  logic                       w_run;
  logic [31:0]                r_pc;
  logic [OW-1:0]              r_drop_cnt;
  logic [OW-1:0]              w_outst_cnt;
  logic [BW-1:0]              w_buf_cnt;
  logic [31:0]                w_tag_head;
  logic [IF_TO_ID_BUS_WD-1:0] w_buf_head;
  logic                       w_redirect_valid;
  logic [31:0]                w_redirect_target;
  logic                       w_req_fire;
  logic                       w_resp_fire;
  logic                       w_pop;
  logic                       w_buf_push;
  logic [SW-1:0]              w_reserved;

  assign w_redirect_valid  = bus.redirect_bus[BR_BUS_WD-1];
  assign w_redirect_target = bus.redirect_bus[31:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_INIT: w_state_nxt = ST_RUN;
      ST_RUN:  w_run       = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Buffer slots already promised to live in-flight requests count as used
  assign w_reserved = SW'(w_outst_cnt) - SW'(r_drop_cnt) + SW'(w_buf_cnt);

  assign bus.inst_req_valid = w_run & ~bus.MemRead & ~w_redirect_valid
                            & (w_outst_cnt < OW'(MAX_OUTST))
                            & (w_reserved < SW'(BUF_DEPTH));
  assign bus.PC             = r_pc;
  assign bus.inst_ready     = (w_outst_cnt != '0);
  assign bus.if_to_id_valid = (w_buf_cnt != '0) & ~w_redirect_valid;
  assign bus.if_to_id_bus   = w_buf_head;

  assign w_req_fire  = bus.inst_req_valid & bus.inst_req_ready;
  assign w_resp_fire = bus.inst_valid & bus.inst_ready;
  assign w_pop       = bus.if_to_id_valid & bus.id_allow_in;
  assign w_buf_push  = w_resp_fire & (r_drop_cnt == '0) & ~w_redirect_valid;

  always_ff @(posedge clk) begin
    if (rst)               r_pc <= RESET_PC;
    else if (w_redirect_valid) r_pc <= w_redirect_target;
    else if (w_req_fire)   r_pc <= r_pc + 32'd4;
  end

  // A response landing in the redirect cycle is discarded directly, not counted
  always_ff @(posedge clk) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (w_redirect_valid)
      r_drop_cnt <= w_outst_cnt - OW'(w_resp_fire);
    else if (w_resp_fire && (r_drop_cnt != '0))
      r_drop_cnt <= r_drop_cnt - OW'(1);
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_resp_fire),
    .o_data  (w_tag_head),
    .o_count (w_outst_cnt)
  );

  fetch_fifo #(
    .WIDTH (IF_TO_ID_BUS_WD),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_redirect_valid),
    .i_push  (w_buf_push),
    .i_data  ({bus.instruction, w_tag_head}),
    .i_pop   (w_pop),
    .o_data  (w_buf_head),
    .o_count (w_buf_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
// ==================================================================
// tb_if_prefetch_stage : directed + random bench for if_prefetch_stage
// Revision: 1.0
// ==================================================================
`default_nettype none

module tb_if_prefetch_stage;
  import if_prefetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_stage_if bus ();

  if_prefetch_stage #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH),
    .MAX_OUTST (MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] memq  [$];
  bit          stale [$];
  logic [63:0] mbuf  [$];
  logic [31:0] exp_fetch;
  logic [31:0] exp_arch;
  bit          in_init;
  bit          mem_en;
  int          n_pop;
  bit          want_first;
  logic [31:0] first_pc;
  logic [31:0] saved_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (stale[i]) if (!stale[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_redir(input bit v, input logic [31:0] t);
    bus.redirect_bus = {v, t};
  endtask

  // One clock: observe mid-cycle, update the reference, then drive memory responses
  task automatic tick();
    bit          redir, req_f, resp_f, pop_f, exp_req, s;
    logic [31:0] p;
    logic [63:0] e;
    @(negedge clk);
    if (rst) begin
      memq.delete();
      stale.delete();
      mbuf.delete();
      in_init   = 1'b1;
      exp_fetch = RST_PC;
      exp_arch  = RST_PC;
    end else begin
      redir   = bus.redirect_bus[32];
      req_f   = bus.inst_req_valid & bus.inst_req_ready;
      resp_f  = bus.inst_valid & bus.inst_ready;
      pop_f   = bus.if_to_id_valid & bus.id_allow_in;
      exp_req = !in_init && !bus.MemRead && !redir && (memq.size() < MAXO)
              && (live_cnt() + mbuf.size() < DEPTH);
      chk("inst_req_valid", 64'(bus.inst_req_valid), 64'(exp_req));
      chk("inst_ready", 64'(bus.inst_ready), 64'(memq.size() > 0));
      chk("if_to_id_valid", 64'(bus.if_to_id_valid), 64'(mbuf.size() > 0 && !redir));
      if (pop_f && mbuf.size() > 0) begin
        e = mbuf.pop_front();
        chk("id_bus", bus.if_to_id_bus, e);
        chk("arch_pc", 64'(bus.if_to_id_bus[31:0]), 64'(exp_arch));
        exp_arch = exp_arch + 32'd4;
        n_pop++;
        if (want_first) begin
          first_pc   = bus.if_to_id_bus[31:0];
          want_first = 1'b0;
        end
      end
      if (req_f) chk("req_pc", 64'(bus.PC), 64'(exp_fetch));
      if (resp_f && memq.size() > 0) begin
        p = memq.pop_front();
        s = stale.pop_front();
        if (!s && !redir) mbuf.push_back({mem_word(p), p});
      end
      if (redir) begin
        mbuf.delete();
        foreach (stale[i]) stale[i] = 1'b1;
        exp_fetch = bus.redirect_bus[31:0];
        exp_arch  = bus.redirect_bus[31:0];
      end else if (req_f) begin
        exp_fetch = exp_fetch + 32'd4;
      end
      if (req_f) begin
        memq.push_back(bus.PC);
        stale.push_back(redir);
      end
      chk("outst_limit", 64'(memq.size() <= MAXO), 64'(1));
      in_init = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.inst_valid  = (memq.size() > 0) && mem_en && !rst;
    bus.instruction = (memq.size() > 0) ? mem_word(memq[0]) : 32'h0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.id_allow_in    = 1'b0;
    bus.redirect_bus   = '0;
    bus.inst_req_ready = 1'b0;
    bus.instruction    = '0;
    bus.inst_valid     = 1'b0;
    bus.MemRead        = 1'b0;
    mem_en             = 1'b1;
    n_pop              = 0;
    want_first         = 1'b0;
    first_pc           = '1;
    in_init            = 1'b1;
    exp_fetch          = RST_PC;
    exp_arch           = RST_PC;

    repeat (3) tick();
    chk("rst_req_valid", 64'(bus.inst_req_valid), 64'(0));
    chk("rst_id_valid", 64'(bus.if_to_id_valid), 64'(0));
    chk("rst_pc", 64'(bus.PC), 64'(RST_PC));
    chk("rst_inst_ready", 64'(bus.inst_ready), 64'(0));

    // Streaming: zero-wait memory, ID always ready
    rst                = 1'b0;
    bus.inst_req_ready = 1'b1;
    bus.id_allow_in    = 1'b1;
    repeat (10) tick();
    n_pop = 0;
    repeat (10) tick();
    chk("stream_rate", 64'(n_pop), 64'(10));

    // ID stall fills the buffer
    bus.id_allow_in = 1'b0;
    repeat (10) tick();
    chk("stall_req_low", 64'(bus.inst_req_valid), 64'(0));
    chk("stall_head_valid", 64'(bus.if_to_id_valid), 64'(1));
    bus.inst_req_ready = 1'b0;
    bus.id_allow_in    = 1'b1;
    n_pop              = 0;
    repeat (8) tick();
    chk("stall_buffered", 64'(n_pop), 64'(DEPTH));
    bus.inst_req_ready = 1'b1;

    // Redirect with two requests outstanding
    mem_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (memq.size() == 2 && !bus.inst_valid) break;
      tick();
    end
    chk("two_outstanding", 64'(memq.size()), 64'(2));
    want_first = 1'b1;
    set_redir(1'b1, 32'h0000_0100);
    tick();
    set_redir(1'b0, 32'h0);
    mem_en = 1'b1;
    repeat (12) tick();
    chk("redir_first_pc", 64'(first_pc), 64'(32'h100));

    // Redirect coinciding with a response and a would-be request
    repeat (6) tick();
    want_first = 1'b1;
    set_redir(1'b1, 32'h0000_0200);
    tick();
    set_redir(1'b0, 32'h0);
    chk("redir_pc_next", 64'(bus.PC), 64'(32'h200));
    repeat (8) tick();
    chk("redir2_first_pc", 64'(first_pc), 64'(32'h200));

    // Data-side read blocks fetch for three cycles
    repeat (4) tick();
    saved_pc    = bus.PC;
    bus.MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("memread_pc_hold", 64'(bus.PC), 64'(saved_pc));
    end
    bus.MemRead = 1'b0;
    repeat (8) tick();

    // Random stalls, backpressure and redirects, with a reset in the middle
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 500; i++) begin
        bus.inst_req_ready = ($urandom_range(0, 3) != 0);
        mem_en             = ($urandom_range(0, 3) != 0);
        bus.id_allow_in    = ($urandom_range(0, 4) != 0);
        bus.MemRead        = ($urandom_range(0, 15) == 0);
        set_redir($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC);
        tick();
      end
      set_redir(1'b0, 32'h0);
      bus.MemRead = 1'b0;
      if (k == 0) begin
        rst = 1'b1;
        repeat (2) tick();
        chk("mid_rst_pc", 64'(bus.PC), 64'(RST_PC));
        chk("mid_rst_id_valid", 64'(bus.if_to_id_valid), 64'(0));
        rst = 1'b0;
      end
    end

    bus.inst_req_ready = 1'b1;
    bus.id_allow_in    = 1'b1;
    mem_en             = 1'b1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 4: instruction buffer entries; power of 2, 2..16.
REQ-003 Parameter MAX_OUTST, default 2: maximum in-flight memory requests; 1..BUF_DEPTH.
REQ-004 Port clk  in  1: single clock; all state changes on posedge.
REQ-005 Port rst  in  1: reset, synchronous and active-high.
REQ-006 Port id_allow_in  in  1: ID accepts a new instruction this cycle.
REQ-007 Port redirect_bus  in  33: {redirect_valid, redirect_target[31:0]} from ID (branch/jump taken).
REQ-008 Port if_to_id_valid  out  1: buffer head valid toward ID.
REQ-009 Port if_to_id_bus  out  64: {instruction[31:0], pc[31:0]} of buffer head.
REQ-010 Port PC  out  32: request address; Port inst_req_valid out 1; Port inst_req_ready in 1.
REQ-011 Port instruction  in  32; Port inst_valid in 1; Port inst_ready out 1: in-order response channel.
REQ-012 Port MemRead  in  1: data-side read in progress; suppresses new instruction requests.

Function
REQ-013 Request fire = inst_req_valid & inst_req_ready; response fire = inst_valid & inst_ready; pop = if_to_id_valid & id_allow_in.
REQ-014 FSM states INIT, RUN; INIT for exactly one cycle after reset, then RUN; no requests in INIT.
REQ-015 inst_req_valid = RUN & ~MemRead & ~redirect_valid & (outst_cnt < MAX_OUTST) & (outst_cnt - drop_cnt + buf_cnt < BUF_DEPTH).
REQ-016 inst_req_valid, once asserted, holds with PC stable until fire unless redirect_valid or MemRead deasserts it.
REQ-017 On request fire: PC <= PC + 4 (mod 2^32); PC pushed into in-order tag queue; outst_cnt += 1.
REQ-018 inst_ready = 1 whenever outst_cnt > 0 (buffer space already reserved by REQ-015).
REQ-019 On response fire: outst_cnt -= 1, tag popped; if drop_cnt > 0 then discard and drop_cnt -= 1, else push {instruction, tag} into buffer.
REQ-020 if_to_id_valid = (buf_cnt != 0) & ~redirect_valid; bus always shows head entry.
REQ-021 On redirect_valid: PC <= redirect_target; buffer emptied; no pop; drop_cnt <= outst_cnt - (response fire ? 1 : 0).
REQ-022 Simultaneous redirect + response: that response discarded; redirect + request: request never issued (REQ-015).
REQ-023 Simultaneous push and pop with buffer full is legal; buf_cnt unchanged.
REQ-024 Steady state, zero-wait memory, ID always ready: one instruction per cycle delivered.
REQ-025 Counters sized $clog2(MAX_OUTST+1) / $clog2(BUF_DEPTH+1) bits; never overflow or underflow.
REQ-026 Pointer wrap-around modulo BUF_DEPTH and MAX_OUTST with no bubble.

Reset
REQ-027 On rst: state INIT, PC = RESET_PC, inst_req_valid = 0, if_to_id_valid = 0, outst_cnt = drop_cnt = buf_cnt = 0, queues empty.
REQ-028 Reset mid-operation abandons in-flight requests; memory is reset on the same rst, no stale responses handled.
REQ-029 if_to_id_bus contents undefined while if_to_id_valid = 0.

Structure
REQ-030 Shared package holds BR_BUS_WD = 33, IF_TO_ID_BUS_WD = 64, default RESET_PC.
REQ-031 One sub-module fetch_fifo (parametrised WIDTH, DEPTH, count output) instantiated for tag queue and instruction buffer.

Verification
REQ-032 Reset, memory ready every cycle, 1-cycle response latency, id_allow_in = 1 -> PCs 0,4,8,... to ID, one per cycle after pipeline fill.
REQ-033 id_allow_in = 0 for 10 cycles -> exactly BUF_DEPTH = 4 entries buffered, inst_req_valid low, no loss on release.
REQ-034 Redirect to 32'h100 with 2 requests outstanding -> both responses dropped, next delivered pc = 32'h100.
REQ-035 Redirect in same cycle as response and as pending request -> response dropped, no request that cycle, PC = target next cycle.
REQ-036 MemRead = 1 for 3 cycles -> inst_req_valid low those cycles, PC unchanged, fetch resumes at same PC.
REQ-037 Random stalls/redirects versus reference model -> ID receives exact architectural PC sequence, counters never exceed limits.
